// File: rtl/wb_ram_loader.sv
// Boot loader in front of the Wishbone RAM: writes a byte-stream image into the RAM,
// verifies its checksum, then hands the RAM port to the CPU and releases CPU reset.
module wb_ram_loader #(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  input  logic [aw-3:0] i_cpu_adr,
  input  logic [31:0]   i_cpu_dat,
  input  logic [3:0]    i_cpu_sel,
  input  logic          i_cpu_we,
  input  logic          i_cpu_cyc,
  output logic [31:0]   o_cpu_rdt,
  output logic          o_cpu_ack,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_cpu_rst,
  output logic          o_err
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_cnt;
  logic [aw-3:0] r_adr;
  logic [1:0]    r_idx;
  logic [31:0]   r_word;
  logic [7:0]    r_sum;
  logic          r_cyc;
  logic          r_cpu_rst;
  logic          w_acc;
  logic          w_ack_wr;
  logic          w_done;

  assign o_rx_ready = (r_state == HDR0) || (r_state == HDR1) ||
                      (r_state == DATA) || (r_state == CSUM);
  assign w_acc      = i_rx_valid & o_rx_ready;
  // r_cyc is only ever high while in WRITE, so this is the single accepted ack per word
  assign w_ack_wr   = r_cyc & i_wb_ack;
  assign w_done     = (r_state == DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      HDR0:    if (w_acc) w_next = HDR1;
      HDR1:    if (w_acc) w_next = ({i_rx_data, r_cnt[7:0]} == 16'd0) ? CSUM : DATA;
      DATA:    if (w_acc && (r_idx == 2'd3)) w_next = WRITE;
      WRITE:   if (w_ack_wr) w_next = (r_cnt == 16'd1) ? CSUM : DATA;
      CSUM:    if (w_acc) w_next = (i_rx_data == r_sum) ? DONE : ERR;
      DONE:    w_next = DONE;
      ERR:     w_next = ERR;
      default: w_next = HDR0;
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_state   <= HDR0;
      r_cnt     <= 16'd0;
      r_adr     <= '0;
      r_idx     <= 2'd0;
      r_sum     <= 8'd0;
      r_cyc     <= 1'b0;
      r_cpu_rst <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_cyc     <= (r_state == WRITE) && !w_ack_wr;
      r_cpu_rst <= !w_done;
      case (r_state)
        HDR0: if (w_acc) r_cnt[7:0] <= i_rx_data;
        HDR1: if (w_acc) begin
          r_cnt[15:8] <= i_rx_data;
          r_adr       <= '0;
          r_idx       <= 2'd0;
        end
        DATA: if (w_acc) begin
          r_sum <= r_sum + i_rx_data;
          r_idx <= r_idx + 2'd1;
        end
        WRITE: if (w_ack_wr) begin
          r_adr <= r_adr + 1'b1;
          r_cnt <= r_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Word assembly is pure datapath and needs no reset
  always_ff @(posedge i_wb_clk) begin
    if ((r_state == DATA) && w_acc) r_word[{r_idx, 3'b000} +: 8] <= i_rx_data;
  end

  // RAM port belongs to the CPU only once the image is verified
  assign o_wb_adr  = w_done ? i_cpu_adr : r_adr;
  assign o_wb_dat  = w_done ? i_cpu_dat : r_word;
  assign o_wb_sel  = w_done ? i_cpu_sel : 4'hF;
  assign o_wb_we   = w_done ? i_cpu_we  : (r_state == WRITE);
  assign o_wb_cyc  = w_done ? i_cpu_cyc : r_cyc;
  assign o_cpu_ack = w_done & i_wb_ack;
  assign o_cpu_rdt = i_wb_rdt;
  assign o_cpu_rst = r_cpu_rst;
  assign o_err     = (r_state == ERR);

endmodule

// File: tb/tb_wb_ram_loader.sv
// Bench for wb_ram_loader: table of images streamed into a small RAM model, RAM writes
// checked against a scoreboard, plus hand-written reset-during-write sequence.
module tb_wb_ram_loader;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int NW    = DEPTH / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [AW-3:0] cpu_adr = '0;
  logic [31:0]   cpu_dat = 32'hDEADBEEF;
  logic [3:0]    cpu_sel = 4'hF;
  logic          cpu_we = 1'b0;
  logic          cpu_cyc = 1'b0;
  logic [31:0]   cpu_rdt;
  logic          cpu_ack;
  logic [AW-3:0] wb_adr;
  logic [31:0]   wb_dat;
  logic [3:0]    wb_sel;
  logic          wb_we;
  logic          wb_cyc;
  logic [31:0]   wb_rdt = 32'd0;
  logic          wb_ack = 1'b0;
  logic          cpu_rst;
  logic          err;

  wb_ram_loader #(.depth(DEPTH)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel),
    .i_cpu_we(cpu_we), .i_cpu_cyc(cpu_cyc),
    .o_cpu_rdt(cpu_rdt), .o_cpu_ack(cpu_ack),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel),
    .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
    .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
    .o_cpu_rst(cpu_rst), .o_err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM model: one-cycle registered ack, one access per cyc pulse
  logic [31:0] mem  [NW];
  logic [31:0] emem [NW];
  initial for (int i = 0; i < NW; i++) begin mem[i] = 32'd0; emem[i] = 32'd0; end

  always @(posedge clk) begin
    wb_ack <= wb_cyc & ~wb_ack;
    if (wb_cyc && !wb_ack) begin
      if (wb_we)
        for (int b = 0; b < 4; b++)
          if (wb_sel[b]) mem[wb_adr][8*b +: 8] <= wb_dat[8*b +: 8];
      wb_rdt <= mem[wb_adr];
    end
  end

  typedef struct packed {
    logic [AW-3:0] adr;
    logic [31:0]   dat;
  } wr_t;
  wr_t sb[$];

  int wr_cnt = 0;
  int cyc_len = 0;
  int bp_cnt = 0;

  // Loader write monitor, active only while the CPU is held in reset
  always @(negedge clk) begin
    if (rx_valid && !rx_ready) bp_cnt++;
    if (rst || !cpu_rst) cyc_len = 0;
    else if (wb_cyc) begin
      if (cyc_len == 0) begin
        wr_cnt++;
        chk("wr_we_sel", {27'd0, wb_we, wb_sel}, {27'd0, 1'b1, 4'hF});
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_adr", {30'd0, wb_adr}, {30'd0, e.adr});
          chk("wr_dat", wb_dat, e.dat);
        end
      end
      cyc_len++;
    end else if (cyc_len != 0) begin
      chk("cyc_len", cyc_len, 2);
      cyc_len = 0;
    end
  end

  typedef struct packed {
    logic [15:0]      n;
    logic [4:0][31:0] w;
    logic             bad_cs;
    logic             bp;
    logic             exp_err;
    logic [7:0]       exp_wr;
  } vec_t;

  task automatic send_byte(input logic [7:0] b, input logic gap);
    int k;
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    while (!rx_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("rx_timeout", 32'd1, 32'd0);
    @(negedge clk);
    if (gap) begin rx_valid = 1'b0; @(negedge clk); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_ready", {31'd0, rx_ready}, 32'd1);
    sb.delete();
    wr_cnt = 0;
    bp_cnt = 0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0]  sum;
    logic [7:0]  cs;
    logic [31:0] w;
    int k;
    do_reset();
    sum = 8'd0;
    for (int i = 0; i < int'(v.n); i++) begin
      w = v.w[i];
      sb.push_back('{adr: (AW-2)'(i % NW), dat: w});
      emem[i % NW] = w;
    end
    send_byte(v.n[7:0], !v.bp);
    send_byte(v.n[15:8], !v.bp);
    for (int i = 0; i < int'(v.n); i++) begin
      w = v.w[i];
      for (int b = 0; b < 4; b++) begin
        sum = sum + w[8*b +: 8];
        send_byte(w[8*b +: 8], !v.bp);
      end
    end
    cs = v.bad_cs ? ((sum == 8'd0) ? 8'd1 : 8'd0) : sum;
    send_byte(cs, 1'b1);
    rx_valid = 1'b0;
    k = 0;
    while (cpu_rst && !err && k < 20) begin @(negedge clk); k++; end
    chk("err", {31'd0, err}, {31'd0, v.exp_err});
    chk("cpu_rst", {31'd0, cpu_rst}, {31'd0, v.exp_err});
    chk("wr_count", wr_cnt, {24'd0, v.exp_wr});
    chk("sb_left", sb.size(), 0);
    chk("ready_after", {31'd0, rx_ready}, 32'd0);
    if (v.bp) chk("bp_seen", {31'd0, bp_cnt != 0}, 32'd1);
    for (int i = 0; i < NW; i++) chk("ram", mem[i], emem[i]);
    // CPU read of word 0: ignored in ERR, passed through in DONE
    cpu_adr = '0;
    cpu_we  = 1'b0;
    cpu_cyc = 1'b1;
    #1;
    chk("cpu_cyc_pass", {31'd0, wb_cyc}, {31'd0, !v.exp_err});
    @(negedge clk);
    chk("cpu_ack", {31'd0, cpu_ack}, {31'd0, !v.exp_err});
    if (!v.exp_err) chk("cpu_rdt", cpu_rdt, emem[0]);
    cpu_we = 1'b1;
    @(negedge clk);
    if (v.exp_err) chk("err_no_cpu_cyc", {31'd0, wb_cyc}, 32'd0);
    cpu_cyc = 1'b0;
    cpu_we  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NW; i++) chk("ram_after_cpu", mem[i], emem[i]);
  endtask

  vec_t tbl [5];

  initial begin
    int k;
    logic [31:0] w;
    tbl[0] = '{n: 16'd2, w: {32'd0, 32'd0, 32'd0, 32'h55667788, 32'h11223344},
               bad_cs: 1'b0, bp: 1'b0, exp_err: 1'b0, exp_wr: 8'd2};
    tbl[1] = '{n: 16'd2, w: {32'd0, 32'd0, 32'd0, 32'h55667788, 32'h11223344},
               bad_cs: 1'b1, bp: 1'b0, exp_err: 1'b1, exp_wr: 8'd2};
    tbl[2] = '{n: 16'd0, w: '0, bad_cs: 1'b0, bp: 1'b0, exp_err: 1'b0, exp_wr: 8'd0};
    tbl[3] = '{n: 16'd5, w: {32'hCAFEF00D, 32'h0BADBEEF, 32'hA5A55A5A, 32'h01020304, 32'hFFEEDDCC},
               bad_cs: 1'b0, bp: 1'b1, exp_err: 1'b0, exp_wr: 8'd5};
    tbl[4] = '{n: 16'd3, w: {32'd0, 32'd0, 32'h80808080, 32'h7F00FF01, 32'h12345678},
               bad_cs: 1'b0, bp: 1'b1, exp_err: 1'b0, exp_wr: 8'd3};

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Reset while the second word's write cycle is on the bus
    do_reset();
    sb.push_back('{adr: (AW-2)'(0), dat: 32'h11223344});
    sb.push_back('{adr: (AW-2)'(1), dat: 32'h55667788});
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? 32'h11223344 : 32'h55667788;
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b1);
    end
    rx_valid = 1'b0;
    k = 0;
    while (!wb_cyc && k < 10) begin @(negedge clk); k++; end
    chk("mid_cyc_seen", {31'd0, wb_cyc}, 32'd1);
    chk("mid_adr", {30'd0, wb_adr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_cyc_drop", {31'd0, wb_cyc}, 32'd0);
    chk("mid_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("mid_ready", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_vec(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
